// File: rtl/wfg_record_spi.sv
// ============================================================================
// wfg_record_spi
// ----------------------------------------------------------------------------
// SPI target (receiver) at the recorder edge of the waveform generator. It is
// the counterpart of wfg_drive_spi and is used both for loopback of that driver
// and for capturing external SPI traffic. SCLK/CS/SDI are asynchronous to clk
// and are synchronised here. Each complete 8/16/24/32-bit frame is emitted as
// a single right-aligned AXI-stream word with tlast set.
//
// Optional feature (compile-time macro):
//   WFG_RECORD_SPI_OVF_COUNT_EN - adds status_ovf_cnt_o[7:0], a saturating
//                                 count of dropped frames (cleared while the
//                                 receiver is disabled).
//
// Ports:
//   clk, rst_n               system clock, asynchronous active-low reset
//   wfg_pat_sync_o           1-cycle pulse when a word enters the output register
//   wfg_axis_tready_i        downstream ready
//   wfg_axis_tvalid_o        output word valid
//   wfg_axis_tlast_o         last flag, high with every word
//   wfg_axis_tdata_o         received word, right-aligned, upper bits zero
//   ctrl_en_q_i              receiver enable
//   cfg_cpol_q_i             SCLK idle level (sample edge is the leading edge)
//   cfg_lsbfirst_q_i         1 = first received bit is bit 0
//   cfg_dff_q_i              frame size 0/1/2/3 = 8/16/24/32 bits
//   cfg_sspol_q_i            0 = CS active low, 1 = CS active high
//   wfg_record_spi_sclk_i    SPI clock pin
//   wfg_record_spi_cs_ni     SPI chip-select pin
//   wfg_record_spi_sdi_i     SPI data pin
//   status_overflow_o        sticky: a frame was dropped (output still pending)
//   status_frame_err_o       sticky: CS dropped before a frame completed
//   status_ovf_cnt_o         dropped-frame count (only with the macro above)
// ============================================================================
module wfg_record_spi #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       wfg_pat_sync_o,
    input  logic                       wfg_axis_tready_i,
    output logic                       wfg_axis_tvalid_o,
    output logic                       wfg_axis_tlast_o,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
    input  logic                       ctrl_en_q_i,
    input  logic                       cfg_cpol_q_i,
    input  logic                       cfg_lsbfirst_q_i,
    input  logic [1:0]                 cfg_dff_q_i,
    input  logic                       cfg_sspol_q_i,
    input  logic                       wfg_record_spi_sclk_i,
    input  logic                       wfg_record_spi_cs_ni,
    input  logic                       wfg_record_spi_sdi_i,
    output logic                       status_overflow_o,
    output logic                       status_frame_err_o
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
    ,
    output logic [7:0]                 status_ovf_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Pin synchronisers. Reset values are the inactive pin levels so that no
    // spurious edge or select is seen right after reset.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sdi_sync  <= '0;
            sclk_hist <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], wfg_record_spi_sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   wfg_record_spi_cs_ni};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0],  wfg_record_spi_sdi_i};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic cs_s;
    logic sdi_s;

    // SDI is taken from the same stage as SCLK so data and clock stay aligned.
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------------
    state_t                     state, state_next;
    logic [AXIS_DATA_WIDTH-1:0] shift_q, shift_next;
    logic [4:0]                 bit_cnt, bit_cnt_next;
    logic                       load_req, load_next;
    logic                       frame_err_set;

    logic       cpol_q;
    logic       lsbfirst_q;
    logic [1:0] dff_q;
    logic       sspol_q;

    logic       sspol_use;
    logic       cs_active;
    logic       sample_edge;
    logic [4:0] last_idx;
    logic [4:0] bit_idx;

    // While idle the live select polarity is used, so a frame can be detected
    // in the same cycle its configuration is captured.
    assign sspol_use   = (state == ST_IDLE) ? cfg_sspol_q_i : sspol_q;
    assign cs_active   = cs_s ^ ~sspol_use;
    assign sample_edge = cpol_q ? (sclk_hist & ~sclk_s) : (~sclk_hist & sclk_s);

    // bit_cnt counts received bits 0..N-1; the write index is mirrored for
    // msb-first frames. N-1 is simply {dff, 3'b111}.
    assign last_idx = {dff_q, 3'b111};
    assign bit_idx  = lsbfirst_q ? bit_cnt : (last_idx - bit_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            load_req   <= 1'b0;
            cpol_q     <= 1'b0;
            lsbfirst_q <= 1'b0;
            dff_q      <= 2'd0;
            sspol_q    <= 1'b0;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            bit_cnt  <= bit_cnt_next;
            load_req <= load_next;
            if (state == ST_IDLE) begin
                cpol_q     <= cfg_cpol_q_i;
                lsbfirst_q <= cfg_lsbfirst_q_i;
                dff_q      <= cfg_dff_q_i;
                sspol_q    <= cfg_sspol_q_i;
            end
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift_q;
        bit_cnt_next  = bit_cnt;
        load_next     = 1'b0;
        frame_err_set = 1'b0;

        case (state)
            ST_IDLE: begin
                shift_next   = '0;
                bit_cnt_next = '0;
                if (ctrl_en_q_i && cs_active) begin
                    state_next = ST_RECEIVE;
                end
            end

            ST_RECEIVE: begin
                // A dropped select wins over a coincident sample edge.
                if (!cs_active) begin
                    state_next    = ST_IDLE;
                    frame_err_set = 1'b1;
                end else if (sample_edge) begin
                    shift_next[bit_idx] = sdi_s;
                    if (bit_cnt == last_idx) begin
                        state_next = ST_HOLD;
                        load_next  = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 5'd1;
                    end
                end
            end

            ST_HOLD: begin
                // The shift register is kept here until the load has used it.
                if (!cs_active) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (!ctrl_en_q_i) begin
            state_next    = ST_IDLE;
            shift_next    = '0;
            bit_cnt_next  = '0;
            load_next     = 1'b0;
            frame_err_set = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Output register, handshake and sticky status. A new word may replace an
    // old one only if the old one is accepted in the same cycle; otherwise the
    // new word is dropped and the overflow is recorded.
    // ------------------------------------------------------------------------
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
    logic [7:0] ovf_cnt;
    assign status_ovf_cnt_o = ovf_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfg_axis_tdata_o   <= '0;
            wfg_axis_tvalid_o  <= 1'b0;
            wfg_pat_sync_o     <= 1'b0;
            status_overflow_o  <= 1'b0;
            status_frame_err_o <= 1'b0;
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
            ovf_cnt            <= 8'd0;
`endif
        end else begin
            wfg_pat_sync_o <= 1'b0;

            if (load_req && (!wfg_axis_tvalid_o || wfg_axis_tready_i)) begin
                wfg_axis_tdata_o  <= shift_q;
                wfg_axis_tvalid_o <= 1'b1;
                wfg_pat_sync_o    <= 1'b1;
            end else if (load_req) begin
                status_overflow_o <= 1'b1;
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
                if (ovf_cnt != 8'hFF) begin
                    ovf_cnt <= ovf_cnt + 8'd1;
                end
`endif
            end else if (wfg_axis_tvalid_o && wfg_axis_tready_i) begin
                wfg_axis_tvalid_o <= 1'b0;
            end

            if (frame_err_set) begin
                status_frame_err_o <= 1'b1;
            end

            if (!ctrl_en_q_i) begin
                status_overflow_o  <= 1'b0;
                status_frame_err_o <= 1'b0;
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
                ovf_cnt            <= 8'd0;
`endif
            end
        end
    end

    // One word per frame, so every word is also the last of its packet.
    assign wfg_axis_tlast_o = wfg_axis_tvalid_o;

endmodule

// File: tb/tb_wfg_record_spi.sv
// ============================================================================
// tb_wfg_record_spi
// ----------------------------------------------------------------------------
// Self-checking bench for wfg_record_spi. An SPI master model drives frames
// (CPHA 0) onto the pins; a scoreboard of expected words is popped on every
// AXI-stream handshake. Expected words are the transmitted data truncated to
// the frame size.
// ============================================================================
module tb_wfg_record_spi;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pat_sync;
    logic        tready;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        ctrl_en;
    logic        cfg_cpol;
    logic        cfg_lsb;
    logic [1:0]  cfg_dff;
    logic        cfg_sspol;
    logic        sclk;
    logic        cs;
    logic        sdi;
    logic        overflow;
    logic        frame_err;
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
    logic [7:0]  ovf_cnt;
`endif

    logic        tready_cmd;
    logic        rand_ready;
    logic        rand_bit;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          pulses = 0;
    int          last_edge_cycle = 0;
    int          tv_rise_cycle = 0;
    logic        tv_prev = 1'b0;
    logic [31:0] exp_q[$];

    assign tready = rand_ready ? rand_bit : tready_cmd;

    always #5 clk = ~clk;

    wfg_record_spi #(
        .AXIS_DATA_WIDTH(32),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .wfg_pat_sync_o       (pat_sync),
        .wfg_axis_tready_i    (tready),
        .wfg_axis_tvalid_o    (tvalid),
        .wfg_axis_tlast_o     (tlast),
        .wfg_axis_tdata_o     (tdata),
        .ctrl_en_q_i          (ctrl_en),
        .cfg_cpol_q_i         (cfg_cpol),
        .cfg_lsbfirst_q_i     (cfg_lsb),
        .cfg_dff_q_i          (cfg_dff),
        .cfg_sspol_q_i        (cfg_sspol),
        .wfg_record_spi_sclk_i(sclk),
        .wfg_record_spi_cs_ni (cs),
        .wfg_record_spi_sdi_i (sdi),
        .status_overflow_o    (overflow),
        .status_frame_err_o   (frame_err)
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
        ,
        .status_ovf_cnt_o     (ovf_cnt)
`endif
    );

    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    always @(posedge clk) begin
        #2;
        rand_bit = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", tdata, 32'hFFFF_FFFF ^ tdata);
                end else begin
                    checkOutput("word", tdata, exp_q.pop_front());
                end
                checkOutput("tlast", {31'd0, tlast}, 32'd1);
            end
            if (pat_sync) pulses++;
            if (tvalid && !tv_prev) tv_rise_cycle = cycle;
            tv_prev = tvalid;
        end else begin
            tv_prev = 1'b0;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Disable, set config and inactive pin levels, then re-enable.
    task automatic setupConfig(input logic cpol, input logic lsb, input logic sspol, input logic [1:0] dff);
        ctrl_en   = 1'b0;
        cfg_cpol  = cpol;
        cfg_lsb   = lsb;
        cfg_sspol = sspol;
        cfg_dff   = dff;
        sclk      = cpol;
        cs        = ~sspol;
        sdi       = 1'b0;
        waitCycles(6);
        ctrl_en = 1'b1;
        waitCycles(2);
    endtask

    // SPI master, CPHA 0: data set on the trailing edge, sampled on the
    // leading edge. Sends nsend bits of a frame; optionally releases CS.
    task automatic applyStimulus(input logic [31:0] word, input int nsend, input int half, input bit release_cs);
        int   nbits;
        int   idx;
        nbits = 8 * (int'(cfg_dff) + 1);
        cs = cfg_sspol;
        waitCycles(half);
        for (int i = 0; i < nsend; i++) begin
            idx = cfg_lsb ? i : (nbits - 1 - i);
            sdi = word[idx];
            waitCycles(half);
            sclk = ~cfg_cpol;
            last_edge_cycle = cycle;
            waitCycles(half);
            sclk = cfg_cpol;
        end
        if (release_cs) begin
            waitCycles(half);
            cs = ~cfg_sspol;
            waitCycles(half + 2);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tvalid) && t < 500) begin
            waitCycles(1);
            t++;
        end
        checkOutput("drain_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        logic [31:0] word;
        logic [63:0] mask;
        int          nbits;
        int          halves[2];
        halves[0] = 2;
        halves[1] = 8;

        rst_n = 1'b0;  ctrl_en = 1'b0;  tready_cmd = 1'b1;  rand_ready = 1'b0;
        cfg_cpol = 1'b0;  cfg_lsb = 1'b0;  cfg_dff = 2'd0;  cfg_sspol = 1'b0;
        sclk = 1'b0;  cs = 1'b1;  sdi = 1'b0;
        waitCycles(3);
        checkOutput("reset_tvalid",   {31'd0, tvalid},    32'd0);
        checkOutput("reset_tdata",    tdata,              32'd0);
        checkOutput("reset_tlast",    {31'd0, tlast},     32'd0);
        checkOutput("reset_sync",     {31'd0, pat_sync},  32'd0);
        checkOutput("reset_overflow", {31'd0, overflow},  32'd0);
        checkOutput("reset_frame_err",{31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        waitCycles(2);

        // 8-bit msb-first, cpol 0, sspol 0
        setupConfig(1'b0, 1'b0, 1'b0, 2'd0);
        pulses = 0;
        exp_q.push_back(32'h0000_00A5);
        applyStimulus(32'hA5, 8, 2, 1'b1);
        drain();
        checkOutput("latency", tv_rise_cycle - last_edge_cycle, SYNC + 2);
        checkOutput("sync_pulses", pulses, 32'd1);
        checkOutput("a5_frame_err", {31'd0, frame_err}, 32'd0);

        // 32-bit lsb-first, cpol 1, sspol 1
        setupConfig(1'b1, 1'b1, 1'b1, 2'd3);
        exp_q.push_back(32'hDEAD_BEEF);
        applyStimulus(32'hDEAD_BEEF, 32, 2, 1'b1);
        drain();
        checkOutput("deadbeef_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("deadbeef_overflow",  {31'd0, overflow},  32'd0);

        // Overflow: two 16-bit frames with the sink stalled
        setupConfig(1'b0, 1'b0, 1'b0, 2'd1);
        tready_cmd = 1'b0;
        exp_q.push_back(32'h0000_1234);
        applyStimulus(32'h1234, 16, 2, 1'b1);
        applyStimulus(32'h5678, 16, 2, 1'b1);
        waitCycles(8);
        checkOutput("ovf_tdata",  tdata,               32'h0000_1234);
        checkOutput("ovf_tvalid", {31'd0, tvalid},     32'd1);
        checkOutput("ovf_flag",   {31'd0, overflow},   32'd1);
`ifdef WFG_RECORD_SPI_OVF_COUNT_EN
        checkOutput("ovf_cnt",    {24'd0, ovf_cnt},    32'd1);
`endif
        tready_cmd = 1'b1;
        drain();
        checkOutput("ovf_sticky", {31'd0, overflow},   32'd1);

        // Frame error: CS released after 5 of 8 bits, then a good frame
        setupConfig(1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(32'hFF, 5, 2, 1'b1);
        waitCycles(10);
        checkOutput("ferr_tvalid", {31'd0, tvalid},    32'd0);
        checkOutput("ferr_flag",   {31'd0, frame_err}, 32'd1);
        exp_q.push_back(32'h0000_003C);
        applyStimulus(32'h3C, 8, 2, 1'b1);
        drain();

        // Reset in the middle of a 24-bit frame
        setupConfig(1'b0, 1'b0, 1'b0, 2'd2);
        applyStimulus(32'h00AB_CDEF, 12, 2, 1'b0);
        rst_n = 1'b0;
        waitCycles(2);
        checkOutput("midrst_tvalid",    {31'd0, tvalid},    32'd0);
        checkOutput("midrst_tdata",     tdata,              32'd0);
        checkOutput("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("midrst_sync",      {31'd0, pat_sync},  32'd0);
        cs = 1'b1;
        sclk = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(4);
        exp_q.push_back(32'h00AB_CDEF);
        applyStimulus(32'h00AB_CDEF, 24, 2, 1'b1);
        drain();
        checkOutput("midrst_after_err", {31'd0, frame_err}, 32'd0);

        // Randomised frames across all sizes, two clock rates, random config
        // and random sink back-pressure.
        for (int d = 0; d < 4; d++) begin
            for (int h = 0; h < 2; h++) begin
                for (int k = 0; k < 3; k++) begin
                    setupConfig(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 2'(d));
                    nbits = 8 * (d + 1);
                    word  = $urandom;
                    mask  = (64'd1 << nbits) - 64'd1;
                    exp_q.push_back(word & mask[31:0]);
                    rand_ready = 1'b1;
                    applyStimulus(word, nbits, halves[h], 1'b1);
                    rand_ready = 1'b0;
                    drain();
                    checkOutput("rand_overflow",  {31'd0, overflow},  32'd0);
                    checkOutput("rand_frame_err", {31'd0, frame_err}, 32'd0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
